// File: rtl/riscv_trace_buffer_if.sv
// Read-port bundle of the trace buffer: first-word-fall-through record stream with valid/ready.
interface riscv_trace_buffer_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            rd_valid;
   logic            rd_ready;
   logic [XLEN-1:0] rd_pc;
   logic [XLEN-1:0] rd_instr;
   logic [XLEN-1:0] rd_result;
   logic [1:0]      rd_flags;  // {mem_write, reg_write}

   // Buffer side drives the record, consumer drives ready.
   modport master (
      output rd_valid,
      output rd_pc,
      output rd_instr,
      output rd_result,
      output rd_flags,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_pc,
      input  rd_instr,
      input  rd_result,
      input  rd_flags,
      output rd_ready
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Execution-trace capture for the single-cycle core: circular record buffer with optional
// PC trigger, stop-when-full or wrap capture, halt (PC self-loop) detection and FWFT drain.
module riscv_trace_buffer #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned HALT_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_enable,
   input  logic                   cfg_mode,
   input  logic                   cfg_trig_en,
   input  logic [XLEN-1:0]        cfg_trig_pc,
   input  logic [XLEN-1:0]        pc_in,
   input  logic [XLEN-1:0]        instr_in,
   input  logic [XLEN-1:0]        alu_result_in,
   input  logic                   reg_write_in,
   input  logic                   mem_write_in,
   riscv_trace_buffer_if.master   rd,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   halted,
   output logic [31:0]            cycle_count,
   output logic [1:0]             state
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned RunW = $clog2(HALT_CYCLES) + 1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } state_e;

   state_e          state_q;
   logic            enable_q;
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;
   logic            overflow_q, halted_q;
   logic [31:0]     cycle_q;
   logic [XLEN-1:0] last_pc_q;
   logic            have_last_q;
   logic [RunW-1:0] run_q;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] res_mem   [DEPTH];
   logic [1:0]      flag_mem  [DEPTH];

   logic            en_rise, trig_hit, push, pop, full, valid;
   logic            same_pc, halt_hit, fill_hit;
   logic [RunW-1:0] run_next;

   assign en_rise  = cfg_enable & ~enable_q;
   assign trig_hit = (pc_in == cfg_trig_pc);
   assign push     = cfg_enable & ~en_rise &
                     ((state_q == StCapture) | ((state_q == StArmed) & trig_hit));
   assign valid    = (count_q != '0);
   assign pop      = valid & rd.rd_ready;
   assign full     = (count_q == CntW'(DEPTH));

   // The trigger store starts a fresh run, so only CAPTURE-state stores extend it.
   assign same_pc  = have_last_q & (state_q == StCapture) & (pc_in == last_pc_q);
   assign run_next = same_pc ? run_q + 1'b1 : '0;
   assign halt_hit = push & (run_next == RunW'(HALT_CYCLES - 1));
   assign fill_hit = push & ~cfg_mode & ~pop & (count_q == CntW'(DEPTH - 1));

   // Control FSM, pointers, occupancy and sticky status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         enable_q    <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         halted_q    <= 1'b0;
         cycle_q     <= '0;
         last_pc_q   <= '0;
         have_last_q <= 1'b0;
         run_q       <= '0;
      end else begin
         enable_q <= cfg_enable;
         if (en_rise) begin
            state_q     <= cfg_trig_en ? StArmed : StCapture;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
            cycle_q     <= '0;
            have_last_q <= 1'b0;
            run_q       <= '0;
         end else begin
            if (!cfg_enable) begin
               state_q <= StIdle;
            end else if ((state_q == StArmed) && trig_hit) begin
               state_q <= StCapture;
            end else if ((state_q == StCapture) && (halt_hit || fill_hit)) begin
               state_q <= StDone;
            end

            if (halt_hit) halted_q <= 1'b1;
            if ((state_q == StCapture) && cfg_enable && (cycle_q != '1)) begin
               cycle_q <= cycle_q + 32'd1;
            end

            if (push) begin
               last_pc_q   <= pc_in;
               have_last_q <= 1'b1;
               run_q       <= run_next;
               wptr_q      <= wptr_q + 1'b1;
            end

            // A push into a full wrap buffer without a pop drops the oldest record.
            if (push && full && !pop) begin
               rptr_q     <= rptr_q + 1'b1;
               overflow_q <= 1'b1;
            end else if (pop) begin
               rptr_q <= rptr_q + 1'b1;
            end

            if (push && !pop && !full) begin
               count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
               count_q <= count_q - 1'b1;
            end
         end
      end
   end

   // Record storage; no reset needed since reads are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr_q]    <= pc_in;
         instr_mem[wptr_q] <= instr_in;
         res_mem[wptr_q]   <= alu_result_in;
         flag_mem[wptr_q]  <= {mem_write_in, reg_write_in};
      end
   end

   assign rd.rd_valid  = valid;
   assign rd.rd_pc     = valid ? pc_mem[rptr_q]    : '0;
   assign rd.rd_instr  = valid ? instr_mem[rptr_q] : '0;
   assign rd.rd_result = valid ? res_mem[rptr_q]   : '0;
   assign rd.rd_flags  = valid ? flag_mem[rptr_q]  : '0;

   assign count       = count_q;
   assign overflow    = overflow_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_q;
   assign state       = state_q;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer (DEPTH=4, HALT_CYCLES=4) with a popped-record scoreboard.
module tb_riscv_trace_buffer;
   localparam int unsigned XLEN = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned HALT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_enable, cfg_mode, cfg_trig_en;
   logic [31:0] cfg_trig_pc, pc_in, instr_in, alu_result_in;
   logic        reg_write_in, mem_write_in;
   logic [2:0]  count;
   logic        overflow, halted;
   logic [31:0] cycle_count;
   logic [1:0]  state;

   riscv_trace_buffer_if #(.XLEN(XLEN)) rd_if ();

   riscv_trace_buffer #(
      .XLEN(XLEN),
      .DEPTH(DEPTH),
      .HALT_CYCLES(HALT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cfg_enable(cfg_enable),
      .cfg_mode(cfg_mode),
      .cfg_trig_en(cfg_trig_en),
      .cfg_trig_pc(cfg_trig_pc),
      .pc_in(pc_in),
      .instr_in(instr_in),
      .alu_result_in(alu_result_in),
      .reg_write_in(reg_write_in),
      .mem_write_in(mem_write_in),
      .rd(rd_if),
      .count(count),
      .overflow(overflow),
      .halted(halted),
      .cycle_count(cycle_count),
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] result;
      logic [1:0]  flags;
   } rec_t;

   rec_t exp_q[$];
   rec_t mon_rec;
   int   n_checks = 0;
   int   n_pass = 0;

   // Expected record for a given PC: instr = {pc[23:0], 0x13}, result = ~pc,
   // reg_write = pc[2], mem_write = pc[3].
   function automatic rec_t mk(input logic [31:0] pc);
      rec_t r;
      r.pc     = pc;
      r.instr  = {pc[23:0], 8'h13};
      r.result = ~pc;
      r.flags  = {pc[3], pc[2]};
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_q.push_back(mk(pc));
   endtask

   // One cycle of core observation, stored (or not) at the next rising edge.
   task automatic step(input logic [31:0] pc);
      pc_in         = pc;
      instr_in      = 32'h13;
      instr_in      = {pc[23:0], instr_in[7:0]};
      alu_result_in = ~pc;
      reg_write_in  = pc[2];
      mem_write_in  = pc[3];
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      rd_if.rd_ready = 1'b1;
      while (count != 0 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      rd_if.rd_ready = 1'b0;
      check({name, "_drained_count"}, count, 0);
      check({name, "_scoreboard_empty"}, exp_q.size(), 0);
   endtask

   // Monitor: every accepted head record must match the next expected record.
   always @(negedge clk) begin
      if (reset && rd_if.rd_valid && rd_if.rd_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pop_unexpected: got pc %0h want no record", rd_if.rd_pc);
         end else begin
            mon_rec = exp_q.pop_front();
            check("pop_record", {rd_if.rd_pc, rd_if.rd_instr, rd_if.rd_result, rd_if.rd_flags},
                  mon_rec);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      cfg_enable = 1'b0;
      cfg_mode = 1'b0;
      cfg_trig_en = 1'b0;
      cfg_trig_pc = '0;
      pc_in = '0;
      instr_in = '0;
      alu_result_in = '0;
      reg_write_in = 1'b0;
      mem_write_in = 1'b0;
      rd_if.rd_ready = 1'b0;

      // Reset values
      #12;
      check("rst_state", state, 0);
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_if.rd_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_halted", halted, 0);
      check("rst_cycle", cycle_count, 0);
      check("rst_rd_pc", rd_if.rd_pc, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Trigger capture, stop mode
      cfg_trig_en = 1'b1;
      cfg_trig_pc = 32'h8;
      cfg_mode = 1'b0;
      cfg_enable = 1'b1;
      step(32'hFC);
      check("t1_armed", state, 1);
      step(32'h0);
      step(32'h4);
      check("t1_still_armed", state, 1);
      check("t1_no_store", count, 0);
      step(32'h8);
      check("t1_capture", state, 2);
      check("t1_first_store_count", count, 1);
      check("t1_first_store_pc", rd_if.rd_pc, 32'h8);
      step(32'hC);
      step(32'h10);
      step(32'h14);
      check("t1_done", state, 3);
      check("t1_full_count", count, 4);
      check("t1_cycles", cycle_count, 3);
      step(32'h18);
      check("t1_done_no_store", count, 4);
      expect_pc(32'h8);
      expect_pc(32'hC);
      expect_pc(32'h10);
      expect_pc(32'h14);
      drain("t1");
      cfg_enable = 1'b0;
      step(32'h0);
      check("t1_idle", state, 0);

      // Wrap mode, no trigger, consumer stalled
      cfg_trig_en = 1'b0;
      cfg_mode = 1'b1;
      cfg_enable = 1'b1;
      step(32'h200);
      check("t2_capture", state, 2);
      check("t2_flushed", count, 0);
      for (int i = 0; i < 6; i++) step(32'(4 * i));
      check("t2_count", count, 4);
      check("t2_overflow", overflow, 1);
      check("t2_head_pc", rd_if.rd_pc, 32'h8);
      cfg_enable = 1'b0;
      step(32'h300);
      check("t2_idle", state, 0);
      check("t2_retained", count, 4);
      check("t2_cycles", cycle_count, 6);
      expect_pc(32'h8);
      expect_pc(32'hC);
      expect_pc(32'h10);
      expect_pc(32'h14);
      drain("t2");

      // Halt detection: 0, 4, 4, 4, 4 in wrap mode
      cfg_enable = 1'b1;
      step(32'h200);
      step(32'h0);
      step(32'h4);
      step(32'h4);
      step(32'h4);
      check("t3_not_yet_halted", halted, 0);
      check("t3_not_yet_done", state, 2);
      step(32'h4);
      check("t3_halted", halted, 1);
      check("t3_done", state, 3);
      check("t3_count", count, 4);
      check("t3_overflow", overflow, 1);
      check("t3_cycles", cycle_count, 5);
      step(32'h4);
      check("t3_done_no_store", count, 4);
      expect_pc(32'h4);
      expect_pc(32'h4);
      rd_if.rd_ready = 1'b1;
      step(32'h4);
      step(32'h4);
      rd_if.rd_ready = 1'b0;
      check("t3_partial_drain", count, 2);

      // Re-arm after halt
      cfg_enable = 1'b0;
      step(32'h0);
      check("t6_idle", state, 0);
      check("t6_halted_sticky", halted, 1);
      check("t6_retained", count, 2);
      cfg_enable = 1'b1;
      step(32'h40);
      check("t6_capture", state, 2);
      check("t6_flushed", count, 0);
      check("t6_halted_clr", halted, 0);
      check("t6_cycles_clr", cycle_count, 0);
      check("t6_overflow_clr", overflow, 0);

      // Push and pop at full in wrap mode
      for (int i = 0; i < 7; i++) expect_pc(32'h40 + 32'(4 * i));
      step(32'h40);
      step(32'h44);
      step(32'h48);
      step(32'h4C);
      check("t4_full", count, 4);
      rd_if.rd_ready = 1'b1;
      step(32'h50);
      step(32'h54);
      step(32'h58);
      check("t4_count_held", count, 4);
      check("t4_no_overflow", overflow, 0);
      check("t4_head_pc", rd_if.rd_pc, 32'h4C);
      rd_if.rd_ready = 1'b0;
      cfg_enable = 1'b0;
      step(32'h5C);
      check("t4_idle_count", count, 4);
      drain("t4");

      // Asynchronous reset mid-capture
      cfg_mode = 1'b0;
      cfg_enable = 1'b1;
      step(32'h200);
      step(32'h80);
      step(32'h84);
      step(32'h88);
      check("t5_count3", count, 3);
      check("t5_capture", state, 2);
      #2;
      reset = 1'b0;
      cfg_enable = 1'b0;
      #1;
      check("t5_state", state, 0);
      check("t5_count", count, 0);
      check("t5_rd_valid", rd_if.rd_valid, 0);
      check("t5_rd_pc", rd_if.rd_pc, 0);
      check("t5_rd_instr", rd_if.rd_instr, 0);
      check("t5_rd_result", rd_if.rd_result, 0);
      check("t5_rd_flags", rd_if.rd_flags, 0);
      check("t5_cycles", cycle_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(32'h0);

      check("final_scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
